// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the serial joystick reader.
package joy_serial_pkg;

    // Reader sequencing states
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftLo,
        StShiftHi,
        StUpdate,
        StGap
    } joy_state_e;

    // Default build: two 12-button pads, ~1.3 us serial tick at 48 MHz
    localparam int DEF_PLAYERS   = 2;
    localparam int DEF_BITS      = 12;
    localparam int DEF_CLK_DIV   = 64;
    localparam int DEF_GAP_TICKS = 16;
    localparam int DEF_DEBOUNCE  = 2;

    localparam int DEF_NBITS = DEF_PLAYERS * DEF_BITS;
    localparam int DEF_IDX_W = $clog2(DEF_NBITS + 1);

    // Bits needed to hold 0..n, never less than one
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit multi-frame debounce: an output bit changes only when the last
// DEBOUNCE raw frames (current one included) all agree.
module joy_debounce #(
    parameter int WIDTH    = 24,
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    if (DEBOUNCE > 1) begin : g_hist
        // Previous DEBOUNCE-1 frames; the current frame is 'raw' itself
        logic [WIDTH-1:0] hist_q [DEBOUNCE-1];
        logic [WIDTH-1:0] all_one;
        logic [WIDTH-1:0] all_zero;

        // Agreement masks across current frame and history
        always_comb begin
            all_one  = raw;
            all_zero = ~raw;
            for (int k = 0; k < DEBOUNCE - 1; k++) begin
                all_one  = all_one & hist_q[k];
                all_zero = all_zero & ~hist_q[k];
            end
        end

        // Shift history and update held outputs on each completed frame
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < DEBOUNCE - 1; k++) begin
                    hist_q[k] <= '0;
                end
                stable <= '0;
            end else if (push) begin
                hist_q[0] <= raw;
                for (int k = 1; k < DEBOUNCE - 1; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
                stable <= all_one | (stable & ~all_zero);
            end
        end
    end else begin : g_pass
        // No debounce: register the raw frame directly
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable <= '0;
            end else if (push) begin
                stable <= raw;
            end
        end
    end

endmodule

// File: rtl/joy_serial_multi.sv
// Serial-shift joystick reader: drives load/clock to a 74HC165-style chain,
// shifts in PLAYERS*BITS active-low buttons and presents debounced buttons.
module joy_serial_multi
    import joy_serial_pkg::*;
#(
    parameter int PLAYERS   = DEF_PLAYERS,
    parameter int BITS      = DEF_BITS,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_done
);

    localparam int N     = PLAYERS * BITS;
    localparam int IDX_W = $clog2(N + 1);
    localparam int DIV_W = cnt_width(CLK_DIV - 1);
    localparam int GAP_W = cnt_width(GAP_TICKS);

    joy_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N-1:0]     raw_q, raw_d;
    logic             joy_clk_d, joy_load_d;
    logic             tick;
    logic             push;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // Free-running serial tick divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Next-state and chain-pin control; everything except UPDATE waits for a tick
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        raw_d      = raw_q;
        joy_clk_d  = joy_clk;
        joy_load_d = joy_load;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && enable) begin
                    joy_load_d = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (tick) begin
                    joy_load_d = 1'b1;
                    idx_d      = '0;
                    state_d    = StShiftLo;
                end
            end
            StShiftLo: begin
                if (tick) begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_q == IDX_W'(i)) raw_d[i] = ~joy_data;
                    end
                    joy_clk_d = 1'b0;
                    state_d   = StShiftHi;
                end
            end
            StShiftHi: begin
                if (tick) begin
                    joy_clk_d = 1'b1;
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = StUpdate;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StShiftLo;
                    end
                end
            end
            StUpdate: begin
                push = 1'b1;
                if (GAP_TICKS > 0) begin
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (tick) begin
                    if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, shift register and registered chain/strobe outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            gap_q      <= '0;
            raw_q      <= '0;
            joy_clk    <= 1'b1;
            joy_load   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            raw_q      <= raw_d;
            joy_clk    <= joy_clk_d;
            joy_load   <= joy_load_d;
            frame_done <= push;
        end
    end

    joy_debounce #(
        .WIDTH    (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .raw    (raw_q),
        .stable (joystick)
    );

endmodule
